// File: rtl/alu_rs_scheduler_if.sv
// rtl/alu_rs_scheduler_if.sv - dispatch/issue/status bundle between the ALU RS entries and their scheduler
interface alu_rs_scheduler_if #(
    parameter int ENTRIES = 4,
    parameter int CNT_W   = 3
);
    logic               flush;
    logic               dispatchValid;
    logic               dispatchReady;
    logic [ENTRIES-1:0] entryBusy;
    logic [ENTRIES-1:0] entrySelectReq;
    logic               aluGrant;
    logic [ENTRIES-1:0] writeReq;
    logic [ENTRIES-1:0] selected;
    logic               execute;
    logic [ENTRIES-1:0] clear;
    logic [CNT_W-1:0]   occupancy;
    logic               full;
    logic               empty;
    logic               countError;

    modport master (
        output flush, dispatchValid, entryBusy, entrySelectReq, aluGrant,
        input  dispatchReady, writeReq, selected, execute, clear,
        input  occupancy, full, empty, countError
    );

    modport slave (
        input  flush, dispatchValid, entryBusy, entrySelectReq, aluGrant,
        output dispatchReady, writeReq, selected, execute, clear,
        output occupancy, full, empty, countError
    );
endinterface

// File: rtl/alu_rs_scheduler.sv
// rtl/alu_rs_scheduler.sv - ALU reservation-station allocator and oldest-ready issue picker
module alu_rs_scheduler #(
    parameter int ENTRIES = 4,
    parameter int CNT_W   = 3
) (
    input  logic             i_clk,
    input  logic             i_resetN,
    alu_rs_scheduler_if.slave bus
);
    // r_age[j][i] = 1 means entry j is older than entry i
    logic [ENTRIES-1:0] r_age [ENTRIES];
    logic [CNT_W-1:0]   r_occ;
    logic               r_count_err;
    logic               r_flush_d;

    logic [ENTRIES-1:0] w_free;
    logic [ENTRIES-1:0] w_lowest;
    logic [ENTRIES-1:0] w_cand;
    logic [ENTRIES-1:0] w_sel;
    logic               w_alloc;
    logic               w_active;
    logic               w_blocked;
    logic [CNT_W-1:0]   w_pop;
    logic [CNT_W-1:0]   w_occ_next;

    assign w_free             = ~bus.entryBusy;
    assign w_lowest           = w_free & (~w_free + ENTRIES'(1));
    assign w_active           = i_resetN & ~bus.flush;
    assign bus.dispatchReady  = (|w_free) & ~bus.flush;
    assign w_alloc            = bus.dispatchValid & bus.dispatchReady & i_resetN;
    assign bus.writeReq       = w_alloc ? w_lowest : '0;

    // A just-written entry is excluded so its busy set never meets an issue clear
    assign w_cand = bus.entrySelectReq & bus.entryBusy & ~bus.writeReq;

    always_comb begin
        w_sel     = '0;
        w_blocked = 1'b0;
        for (int i = 0; i < ENTRIES; i++) begin
            w_blocked = 1'b0;
            for (int j = 0; j < ENTRIES; j++) begin
                w_blocked = w_blocked | (w_cand[j] & r_age[j][i]);
            end
            w_sel[i] = w_cand[i] & ~w_blocked;
        end
    end

    assign bus.selected = w_active ? w_sel : '0;
    assign bus.execute  = (|bus.selected) & bus.aluGrant;
    assign bus.clear    = {ENTRIES{bus.flush}};

    always_comb begin
        w_pop = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            w_pop = w_pop + CNT_W'(bus.entryBusy[i]);
        end
    end

    assign w_occ_next = r_occ + CNT_W'(w_alloc) - CNT_W'(bus.execute);

    always_ff @(posedge i_clk or negedge i_resetN) begin
        if (!i_resetN) begin
            for (int j = 0; j < ENTRIES; j++) begin
                r_age[j] <= '0;
            end
            r_occ       <= '0;
            r_count_err <= 1'b0;
            r_flush_d   <= 1'b0;
        end else begin
            r_flush_d <= bus.flush;
            if (bus.flush) begin
                for (int j = 0; j < ENTRIES; j++) begin
                    r_age[j] <= '0;
                end
                r_occ <= '0;
            end else begin
                // New entry becomes youngest: its row clears, its column sets elsewhere
                if (w_alloc) begin
                    for (int j = 0; j < ENTRIES; j++) begin
                        if (bus.writeReq[j]) begin
                            r_age[j] <= '0;
                        end else begin
                            r_age[j] <= r_age[j] | bus.writeReq;
                        end
                    end
                end
                r_occ <= w_occ_next;
            end
            // The flush cycle and the one after are skipped while entries settle
            if (!bus.flush && !r_flush_d && (r_occ != w_pop)) begin
                r_count_err <= 1'b1;
            end
        end
    end

    assign bus.occupancy  = r_occ;
    assign bus.full       = (r_occ == CNT_W'(ENTRIES));
    assign bus.empty      = (r_occ == '0);
    assign bus.countError = r_count_err;
endmodule

// File: tb/tb_alu_rs_scheduler.sv
// tb/tb_alu_rs_scheduler.sv - self-checking bench for alu_rs_scheduler
module tb_alu_rs_scheduler;
    logic clk;
    logic resetN;

    alu_rs_scheduler_if #(.ENTRIES(4), .CNT_W(3)) bus ();

    alu_rs_scheduler #(.ENTRIES(4), .CNT_W(3)) dut (
        .i_clk    (clk),
        .i_resetN (resetN),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       dv;
        logic [3:0] sreq;
        logic       grant;
        logic       flush;
        logic [3:0] wr;
        logic [3:0] sel;
        logic       exe;
        logic       rdy;
        logic [2:0] occ;
    } vec_t;

    vec_t       vecs[$];
    vec_t       exp_q[$];
    logic [3:0] tb_busy;
    int         n_cmp;
    int         n_err;

    function automatic vec_t mk(input logic dv, input logic [3:0] sreq, input logic grant,
                                input logic flush, input logic [3:0] wr, input logic [3:0] sel,
                                input logic exe, input logic rdy, input logic [2:0] occ);
        vec_t v;
        v.dv = dv; v.sreq = sreq; v.grant = grant; v.flush = flush;
        v.wr = wr; v.sel = sel; v.exe = exe; v.rdy = rdy; v.occ = occ;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        vec_t e;
        @(posedge clk);
        #1;
        bus.dispatchValid  = v.dv;
        bus.entrySelectReq = v.sreq;
        bus.aluGrant       = v.grant;
        bus.flush          = v.flush;
        bus.entryBusy      = tb_busy;
        exp_q.push_back(v);
        @(negedge clk);
        e = exp_q.pop_front();
        chk($sformatf("v%0d writeReq", idx),   8'(bus.writeReq),      8'(e.wr));
        chk($sformatf("v%0d selected", idx),   8'(bus.selected),      8'(e.sel));
        chk($sformatf("v%0d execute", idx),    8'(bus.execute),       8'(e.exe));
        chk($sformatf("v%0d ready", idx),      8'(bus.dispatchReady), 8'(e.rdy));
        chk($sformatf("v%0d occupancy", idx),  8'(bus.occupancy),     8'(e.occ));
        chk($sformatf("v%0d full", idx),       8'(bus.full),          8'(e.occ == 3'd4));
        chk($sformatf("v%0d empty", idx),      8'(bus.empty),         8'(e.occ == 3'd0));
        chk($sformatf("v%0d clear", idx),      8'(bus.clear),         8'({4{e.flush}}));
        chk($sformatf("v%0d countError", idx), 8'(bus.countError),    8'd0);
        // Entry model: busy sets on write, drops on issue, all drop on flush
        if (e.flush) tb_busy = 4'b0000;
        else         tb_busy = (tb_busy | e.wr) & ~(e.exe ? e.sel : 4'b0000);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        n_cmp = 0;
        n_err = 0;
        tb_busy = 4'b0000;

        // dispatch 4, 5th blocked, flush with dispatch pending
        vecs.push_back(mk(1, 4'b0000, 0, 0, 4'b0001, 4'b0000, 0, 1, 3'd0));
        vecs.push_back(mk(1, 4'b0000, 0, 0, 4'b0010, 4'b0000, 0, 1, 3'd1));
        vecs.push_back(mk(1, 4'b0000, 0, 0, 4'b0100, 4'b0000, 0, 1, 3'd2));
        vecs.push_back(mk(1, 4'b0000, 0, 0, 4'b1000, 4'b0000, 0, 1, 3'd3));
        vecs.push_back(mk(1, 4'b0000, 0, 0, 4'b0000, 4'b0000, 0, 0, 3'd4));
        vecs.push_back(mk(1, 4'b1111, 1, 1, 4'b0000, 4'b0000, 0, 0, 3'd4));
        vecs.push_back(mk(0, 4'b0000, 0, 0, 4'b0000, 4'b0000, 0, 1, 3'd0));
        // build age order 2,0,1 then issue oldest first
        vecs.push_back(mk(1, 4'b0000, 0, 0, 4'b0001, 4'b0000, 0, 1, 3'd0));
        vecs.push_back(mk(1, 4'b0000, 0, 0, 4'b0010, 4'b0000, 0, 1, 3'd1));
        vecs.push_back(mk(1, 4'b0000, 0, 0, 4'b0100, 4'b0000, 0, 1, 3'd2));
        vecs.push_back(mk(0, 4'b0011, 1, 0, 4'b0000, 4'b0001, 1, 1, 3'd3));
        vecs.push_back(mk(0, 4'b0010, 1, 0, 4'b0000, 4'b0010, 1, 1, 3'd2));
        vecs.push_back(mk(1, 4'b0000, 0, 0, 4'b0001, 4'b0000, 0, 1, 3'd1));
        vecs.push_back(mk(1, 4'b0000, 0, 0, 4'b0010, 4'b0000, 0, 1, 3'd2));
        vecs.push_back(mk(0, 4'b0111, 1, 0, 4'b0000, 4'b0100, 1, 1, 3'd3));
        vecs.push_back(mk(0, 4'b0011, 1, 0, 4'b0000, 4'b0001, 1, 1, 3'd2));
        // aluGrant withheld, then given
        vecs.push_back(mk(0, 4'b0010, 0, 0, 4'b0000, 4'b0010, 0, 1, 3'd1));
        vecs.push_back(mk(0, 4'b0010, 0, 0, 4'b0000, 4'b0010, 0, 1, 3'd1));
        vecs.push_back(mk(0, 4'b0010, 1, 0, 4'b0000, 4'b0010, 1, 1, 3'd1));
        vecs.push_back(mk(0, 4'b0000, 0, 0, 4'b0000, 4'b0000, 0, 1, 3'd0));
        // simultaneous alloc and issue; written entry not selected
        vecs.push_back(mk(1, 4'b0000, 0, 0, 4'b0001, 4'b0000, 0, 1, 3'd0));
        vecs.push_back(mk(1, 4'b0000, 0, 0, 4'b0010, 4'b0000, 0, 1, 3'd1));
        vecs.push_back(mk(1, 4'b0000, 0, 0, 4'b0100, 4'b0000, 0, 1, 3'd2));
        vecs.push_back(mk(1, 4'b1001, 1, 0, 4'b1000, 4'b0001, 1, 1, 3'd3));
        vecs.push_back(mk(0, 4'b0000, 0, 0, 4'b0000, 4'b0000, 0, 1, 3'd3));
        vecs.push_back(mk(0, 4'b1010, 1, 0, 4'b0000, 4'b0010, 1, 1, 3'd3));
        vecs.push_back(mk(0, 4'b1000, 1, 0, 4'b0000, 4'b1000, 1, 1, 3'd2));
        vecs.push_back(mk(0, 4'b0100, 1, 0, 4'b0000, 4'b0100, 1, 1, 3'd1));
        vecs.push_back(mk(0, 4'b0000, 0, 0, 4'b0000, 4'b0000, 0, 1, 3'd0));

        // reset state with live-looking inputs
        resetN             = 1'b0;
        bus.flush          = 1'b0;
        bus.dispatchValid  = 1'b1;
        bus.entrySelectReq = 4'b1111;
        bus.aluGrant       = 1'b1;
        bus.entryBusy      = 4'b0011;
        #12;
        chk("rst writeReq",   8'(bus.writeReq),   8'd0);
        chk("rst selected",   8'(bus.selected),   8'd0);
        chk("rst execute",    8'(bus.execute),    8'd0);
        chk("rst occupancy",  8'(bus.occupancy),  8'd0);
        chk("rst empty",      8'(bus.empty),      8'd1);
        chk("rst full",       8'(bus.full),       8'd0);
        chk("rst countError", 8'(bus.countError), 8'd0);
        bus.dispatchValid  = 1'b0;
        bus.entrySelectReq = 4'b0000;
        bus.aluGrant       = 1'b0;
        bus.entryBusy      = 4'b0000;
        #1 resetN = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            run_vec(i, vecs[i]);
        end

        // injected busy bit makes occupancy disagree for one edge
        @(posedge clk); #1;
        bus.dispatchValid  = 1'b0;
        bus.entrySelectReq = 4'b0000;
        bus.aluGrant       = 1'b0;
        bus.entryBusy      = 4'b0100;
        @(negedge clk);
        chk("cerr before edge", 8'(bus.countError), 8'd0);
        @(posedge clk); #1;
        bus.entryBusy = 4'b0000;
        @(negedge clk);
        chk("cerr raised", 8'(bus.countError), 8'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("cerr sticky", 8'(bus.countError), 8'd1);
        #1 resetN = 1'b0;
        #1;
        chk("cerr reset", 8'(bus.countError), 8'd0);
        #1 resetN = 1'b1;

        // reset dropped mid-fill
        @(posedge clk); #1;
        bus.dispatchValid = 1'b1;
        bus.entryBusy     = 4'b0000;
        @(negedge clk);
        chk("fill wr0", 8'(bus.writeReq), 8'b0001);
        @(posedge clk); #1;
        bus.entryBusy = 4'b0001;
        @(negedge clk);
        chk("fill wr1", 8'(bus.writeReq), 8'b0010);
        chk("fill occ1", 8'(bus.occupancy), 8'd1);
        @(posedge clk); #1;
        bus.entryBusy      = 4'b0011;
        bus.entrySelectReq = 4'b0011;
        bus.aluGrant       = 1'b1;
        #2;
        chk("fill occ2", 8'(bus.occupancy), 8'd2);
        chk("fill sel", 8'(bus.selected), 8'b0001);
        resetN = 1'b0;
        #1;
        chk("midrst writeReq",  8'(bus.writeReq),  8'd0);
        chk("midrst selected",  8'(bus.selected),  8'd0);
        chk("midrst execute",   8'(bus.execute),   8'd0);
        chk("midrst occupancy", 8'(bus.occupancy), 8'd0);
        chk("midrst empty",     8'(bus.empty),     8'd1);
        bus.dispatchValid  = 1'b0;
        bus.entrySelectReq = 4'b0000;
        bus.aluGrant       = 1'b0;
        bus.entryBusy      = 4'b0000;
        #1 resetN = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("post cerr", 8'(bus.countError), 8'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
